// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode classes,
// opcode values, ALU commands, datapath select encodings and fault codes.
package uc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_ERROR     = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_R, CLS_LW, CLS_SW, CLS_BEQ, CLS_J,
    CLS_ADDI, CLS_ANDI, CLS_ORI, CLS_SLTI, CLS_BAD
  } cls_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic cls_t decode_class(input logic [5:0] op);
    case (op)
      OP_R:    return CLS_R;
      OP_LW:   return CLS_LW;
      OP_SW:   return CLS_SW;
      OP_BEQ:  return CLS_BEQ;
      OP_J:    return CLS_J;
      OP_ADDI: return CLS_ADDI;
      OP_ANDI: return CLS_ANDI;
      OP_ORI:  return CLS_ORI;
      OP_SLTI: return CLS_SLTI;
      default: return CLS_BAD;
    endcase
  endfunction

endpackage

// File: rtl/uc_mem_timeout.sv
// Counts consecutive memory wait cycles; expired flags the MEM_TIMEOUT-th one.
module uc_mem_timeout #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of wait cycles already completed in this state.
  assign expired = waiting && (cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (waiting && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_uc.sv
// Moore control FSM for the multi-cycle MIPS-subset datapath, with memory
// wait-state stalling, hung-memory timeout and illegal-opcode trap.
module multicycle_uc import uc_pkg::*; #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [3:0]         state_dbg
);

  state_t     state, state_next;
  cls_t       cls;
  logic       fault_q;
  logic [1:0] code_q, code_next;
  logic       mem_state, waiting, expired, clear;
  logic [2:0] op3;

  assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  assign waiting   = mem_state && !mem_ready;
  // Any state change re-arms the counter, so each memory state starts from zero.
  assign clear     = mem_ready || (state_next != state);

  uc_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .waiting (waiting),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    code_next  = code_q;
    case (state)
      S_FETCH: begin
        if (mem_ready) state_next = S_DECODE;
        else if (expired) begin
          state_next = S_ERROR;
          code_next  = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (decode_class(opcode))
          CLS_LW, CLS_SW:                        state_next = S_MEM_ADDR;
          CLS_R:                                 state_next = S_EXEC_R;
          CLS_ADDI, CLS_ANDI, CLS_ORI, CLS_SLTI: state_next = S_EXEC_I;
          CLS_BEQ:                               state_next = S_BRANCH;
          CLS_J:                                 state_next = S_JUMP;
          default: begin
            state_next = S_ERROR;
            code_next  = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_next = (cls == CLS_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ, S_MEM_WRITE: begin
        if (mem_ready) state_next = (state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        else if (expired) begin
          state_next = S_ERROR;
          code_next  = FAULT_TIMEOUT;
        end
      end
      S_EXEC_R: state_next = S_R_WB;
      S_EXEC_I: state_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cls     <= CLS_NONE;
      fault_q <= 1'b0;
      code_q  <= FAULT_NONE;
    end else begin
      state   <= state_next;
      code_q  <= code_next;
      fault_q <= fault_q || (state_next == S_ERROR);
      if (state == S_DECODE) cls <= decode_class(opcode);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    op3           = ALU_FUNCT;
    instr_done    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          op3       = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          op3       = ALU_ADD;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          op3       = ALU_ADD;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: alu_src_a = 1'b1;
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          case (cls)
            CLS_ANDI: op3 = ALU_AND;
            CLS_ORI:  op3 = ALU_OR;
            CLS_SLTI: op3 = ALU_SLT;
            default:  op3 = ALU_ADD;
          endcase
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          op3           = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_op     = ALUOP_W'(op3);
  assign fault      = fault_q && !rst;
  assign fault_code = rst ? FAULT_NONE : code_q;
  assign state_dbg  = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_uc.sv
// Directed bench for multicycle_uc: per-cycle state, strobe and fault checks
// against hand-computed control words.
module tb_multicycle_uc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, instr_done, fault;
  logic [1:0] alu_src_b, pc_source, fault_code;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;

  multicycle_uc #(.ALUOP_W(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .instr_done(instr_done), .fault(fault),
    .fault_code(fault_code), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Control word: pcw pcwc iord mr mw irw m2r rw rd asa asb[2] pcs[2] aop[3] done
  logic [17:0] ctl;
  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, pc_source,
                alu_op, instr_done};

  function automatic logic [17:0] mk(input logic pcw, pcwc, iord, mr, mw, irw,
                                     m2r, rw, rd, asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] aop,
                                     input logic done);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, asb, pcs, aop, done};
  endfunction

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010, ANDI = 6'b001100;
  localparam logic [5:0] BAD = 6'b111111;

  logic [17:0] f_rdy, f_wait, dec, maddr, mread, mwb, mwr_rdy, mwr_wait;
  logic [17:0] exr, rwb, exi_add, exi_and, exi_or, exi_slt, iwb, br, jmp, zero;

  initial begin
    f_rdy    = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b001,0);
    f_wait   = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b001,0);
    dec      = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b001,0);
    maddr    = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0);
    mread    = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0);
    mwb      = mk(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000,1);
    mwr_rdy  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,1);
    mwr_wait = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0);
    exr      = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0);
    rwb      = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,1);
    exi_add  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0);
    exi_and  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b011,0);
    exi_or   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0);
    exi_slt  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b101,0);
    iwb      = mk(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,3'b000,1);
    br       = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b010,1);
    jmp      = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,1);
    zero     = '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs mid-cycle, let outputs settle, check state/controls/fault.
  task automatic step(input string tag, input logic r, input logic rdy,
                      input logic [5:0] op, input logic [3:0] st,
                      input logic [17:0] c, input logic [2:0] f);
    @(negedge clk);
    rst = r;
    mem_ready = rdy;
    opcode = op;
    #1;
    chk({tag, ".state"}, 32'(state_dbg), 32'(st));
    chk({tag, ".ctl"},   32'(ctl),       32'(c));
    chk({tag, ".fault"}, 32'({fault, fault_code}), 32'(f));
  endtask

  initial begin
    // reset
    step("rst0", 1, 1, R, 0, zero, 3'b000);
    step("rst1", 1, 0, R, 0, zero, 3'b000);

    // R-type, zero waits
    step("r.f",  0, 1, R, 0, f_rdy, 0);
    step("r.d",  0, 1, R, 1, dec,   0);
    step("r.ex", 0, 1, R, 6, exr,   0);
    step("r.wb", 0, 1, R, 7, rwb,   0);

    // lw with three wait cycles in MEM_READ (8 cycles)
    step("lw.f",  0, 1, LW, 0, f_rdy, 0);
    step("lw.d",  0, 1, LW, 1, dec,   0);
    step("lw.a",  0, 1, LW, 2, maddr, 0);
    step("lw.w1", 0, 0, LW, 3, mread, 0);
    step("lw.w2", 0, 0, LW, 3, mread, 0);
    step("lw.w3", 0, 0, LW, 3, mread, 0);
    step("lw.rd", 0, 1, LW, 3, mread, 0);
    step("lw.wb", 0, 1, LW, 4, mwb,   0);

    // beq then j
    step("beq.f", 0, 1, BEQ, 0, f_rdy, 0);
    step("beq.d", 0, 1, BEQ, 1, dec,   0);
    step("beq.b", 0, 1, BEQ, 10, br,   0);
    step("j.f",   0, 1, J, 0, f_rdy, 0);
    step("j.d",   0, 1, J, 1, dec,   0);
    step("j.j",   0, 0, J, 11, jmp,  0);

    // I-ALU variants; opcode changes after DECODE must not affect alu_op
    step("addi.f",  0, 1, ADDI, 0, f_rdy,   0);
    step("addi.d",  0, 1, ADDI, 1, dec,     0);
    step("addi.ex", 0, 1, BAD,  8, exi_add, 0);
    step("addi.wb", 0, 1, BAD,  9, iwb,     0);
    step("ori.f",   0, 1, ORI, 0, f_rdy,  0);
    step("ori.d",   0, 1, ORI, 1, dec,    0);
    step("ori.ex",  0, 1, ORI, 8, exi_or, 0);
    step("ori.wb",  0, 1, ORI, 9, iwb,    0);
    step("slti.f",  0, 1, SLTI, 0, f_rdy,   0);
    step("slti.d",  0, 1, SLTI, 1, dec,     0);
    step("slti.ex", 0, 1, SLTI, 8, exi_slt, 0);
    step("slti.wb", 0, 1, SLTI, 9, iwb,     0);
    step("andi.f",  0, 1, ANDI, 0, f_rdy,   0);
    step("andi.d",  0, 1, ANDI, 1, dec,     0);
    step("andi.ex", 0, 1, ANDI, 8, exi_and, 0);
    step("andi.wb", 0, 1, ANDI, 9, iwb,     0);

    // sw with three waits then ready on the 4th waiting-eligible cycle
    step("sw.f",  0, 1, SW, 0, f_rdy,    0);
    step("sw.d",  0, 1, SW, 1, dec,      0);
    step("sw.a",  0, 1, SW, 2, maddr,    0);
    step("sw.w1", 0, 0, SW, 5, mwr_wait, 0);
    step("sw.w2", 0, 0, SW, 5, mwr_wait, 0);
    step("sw.w3", 0, 0, SW, 5, mwr_wait, 0);
    step("sw.wr", 0, 1, SW, 5, mwr_rdy,  0);

    // illegal opcode trap
    step("ill.f", 0, 1, BAD, 0, f_rdy, 0);
    step("ill.d", 0, 1, BAD, 1, dec,   0);
    for (int i = 0; i < 20; i++)
      step("ill.err", 0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 12, zero, 3'b101);
    step("ill.rst", 1, 1, R, 0, zero, 3'b000);
    step("ill.f2",  0, 1, R, 0, f_rdy, 0);
    step("ill.d2",  0, 1, R, 1, dec,   0);

    // memory timeout in FETCH
    step("to.rst", 1, 0, R, 0, zero,   0);
    step("to.w1",  0, 0, R, 0, f_wait, 0);
    step("to.w2",  0, 0, R, 0, f_wait, 0);
    step("to.w3",  0, 0, R, 0, f_wait, 0);
    step("to.w4",  0, 0, R, 0, f_wait, 0);
    step("to.err", 0, 0, R, 12, zero,  3'b110);
    step("to.hld", 0, 1, R, 12, zero,  3'b110);

    // ready on the 4th wait cycle wins over the timeout
    step("tw.rst", 1, 0, J, 0, zero,   0);
    step("tw.w1",  0, 0, J, 0, f_wait, 0);
    step("tw.w2",  0, 0, J, 0, f_wait, 0);
    step("tw.w3",  0, 0, J, 0, f_wait, 0);
    step("tw.rd",  0, 1, J, 0, f_rdy,  0);
    step("tw.d",   0, 1, J, 1, dec,    0);
    step("tw.j",   0, 1, J, 11, jmp,   0);

    // rst during MEM_WRITE aborts the store
    step("sr.f",   0, 1, SW, 0, f_rdy,    0);
    step("sr.d",   0, 1, SW, 1, dec,      0);
    step("sr.a",   0, 1, SW, 2, maddr,    0);
    step("sr.w",   0, 0, SW, 5, mwr_wait, 0);
    step("sr.r1",  1, 0, SW, 0, zero,     0);
    step("sr.r2",  1, 1, SW, 0, zero,     0);
    step("sr.f2",  0, 1, SW, 0, f_rdy,    0);
    step("sr.d2",  0, 1, SW, 1, dec,      0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_uc.md
# multicycle_uc

Multi-cycle control unit for the MIPS-subset datapath. It replaces the single-cycle combinational decoder with a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks. It stalls on a memory-ready handshake, times out on a hung memory, and traps illegal opcodes. It sits between the instruction register opcode field and the shared multi-cycle datapath (PC, IR, MDR, register file, ALU, unified memory).

## Interface
Parameters:
- ALUOP_W, 3: width of alu_op; must be >= 3.
- MEM_TIMEOUT, 15: maximum consecutive cycles a memory state waits for mem_ready before a fault; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  out  1 each  datapath strobes and selects.
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alu_op  out  ALUOP_W  ALU command; upper bits beyond bit 2 are 0.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- fault  out  1  sticky; set on entry to ERROR.
- fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout.
- state_dbg  out  4  current state encoding.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, ERROR.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, slti 001010.
- alu_op: 000 funct, 001 add, 010 sub, 011 and, 100 or, 101 slt.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00. ir_write and pc_write are asserted only while mem_ready=1, and the FSM then goes to DECODE. Otherwise it holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add. Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R -> EXEC_R
  - I-ALU -> EXEC_I
  - beq -> BRANCH
  - j -> JUMP
  - other -> ERROR with code 01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. lw -> MEM_READ, sw -> MEM_WRITE. The opcode class is latched in DECODE.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=funct.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op from the latched opcode.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
- Retiring states (MEM_WB, MEM_WRITE with mem_ready, R_WB, I_WB, BRANCH, JUMP) pulse instr_done and return to FETCH.
- Timeout counter:
  - Clears on every entry to FETCH, MEM_READ or MEM_WRITE, and whenever mem_ready=1.
  - Increments on each waiting cycle.
  - On reaching MEM_TIMEOUT with mem_ready still 0: go to ERROR with code 10, and drop mem_read/mem_write from the next cycle.
- ERROR: all strobes 0, fault=1. Held until rst; no other input leaves it.
- Any output not listed for a state is 0.

## Timing
- Outputs are Moore: decoded from the registered state and the latched opcode class. Exceptions are ir_write, pc_write in FETCH and instr_done in MEM_WRITE, which are additionally qualified by mem_ready.
- Reset:
  - While rst=1: state=FETCH, latched class cleared, counter=0, fault=0, fault_code=00, and all outputs forced to 0.
  - First active FETCH is the cycle after rst falls.
  - rst mid-instruction aborts it with no further strobes.
- Latency with zero wait states, FETCH to retire inclusive:
  - R-type 4 cycles
  - lw 5
  - sw 4
  - beq 3
  - j 3
  - I-ALU 4
- Each mem_ready=0 cycle adds one cycle.
- mem_ready is ignored in non-memory states.
- The timeout fires on the MEM_TIMEOUT-th consecutive wait cycle. mem_ready=1 on that same cycle wins: normal progress, no fault.

## Structure
- Package uc_pkg holds:
  - the state enum
  - opcode localparams
  - alu_op codes
  - alu_src_b and pc_source encodings
  - fault_code values
- Sub-module uc_mem_timeout: the wait counter. It has inputs clear and waiting, and outputs expired. It is parameterised by MEM_TIMEOUT.
- The main module contains the next-state logic, the state register and the output decode.

## Test plan
- Reset, then R-type with mem_ready tied 1: states FETCH, DECODE, EXEC_R, R_WB; reg_dst=1 and reg_write=1 on cycle 4; instr_done on cycle 4; the next FETCH follows.
- lw with mem_ready low for 3 cycles in MEM_READ: retires in 8 cycles; mem_to_reg=1 only in MEM_WB; one instr_done pulse.
- beq followed by j: pc_write_cond=1 with pc_source=01 on cycle 3; pc_write=1 with pc_source=10 on the j's cycle 3.
- opcode 111111 in DECODE: next state ERROR, fault=1, fault_code=01, all strobes 0 for 20 cycles; rst clears everything.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH: ERROR with code 10 after 4 wait cycles. A second run asserting mem_ready on wait cycle 4 completes normally.
- rst asserted during MEM_WRITE: no further mem_write, outputs 0 while rst=1, FETCH resumes the cycle after release.
